// File: rtl/boron_dec_core.sv
// Iterative BORON 64-bit block decryption core: UNROLL rounds per clock from an
// external round-key store, then a whitening XOR, with valid/ready on both sides.

module boron_dec_round (
  input  logic [63:0] x,
  input  logic [63:0] k,
  output logic [63:0] y
);
  // Inverse S-box packed as nibble table, entry n at bits [4n+3:4n]
  localparam logic [63:0] ISB = 64'hB086_275C_4FD1_E93A;

  function automatic logic [15:0] rotl(input logic [15:0] w, input int unsigned r);
    return (w << r) | (w >> (16 - r));
  endfunction

  function automatic logic [15:0] bswap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  logic [63:0] a, s;
  logic [15:0] v3, v2, v1, v0;

  always_comb begin
    a  = x ^ k;
    v3 = a[63:48] ^ a[47:32];
    v2 = a[47:32] ^ a[31:16] ^ a[15:0];
    v1 = a[63:48] ^ a[47:32] ^ a[31:16];
    v0 = a[31:16] ^ a[15:0];
    s  = {bswap(rotl(v3, 7)), bswap(rotl(v2, 9)), bswap(rotl(v1, 12)), bswap(rotl(v0, 15))};
    y  = '0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = ISB[{s[4*n +: 4], 2'b00} +: 4];
  end
endmodule

module boron_dec_core #(
  parameter int ROUNDS = 25,
  parameter int UNROLL = 1,
  parameter int AW     = $clog2(ROUNDS+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          din,
  output logic [AW-1:0]        rk_addr,
  input  logic [64*UNROLL-1:0] rk_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          dout
);
  localparam int N  = ROUNDS / UNROLL;
  localparam int CW = $clog2(N) + 1;

  if (ROUNDS % UNROLL != 0) begin : g_bad_unroll
    $error("boron_dec_core: UNROLL must divide ROUNDS");
  end

  typedef enum logic [2:0] {IDLE, RUN, FINAL, DONE} st_t;

  st_t                      st, st_nx;
  logic [63:0]              sreg, sreg_nx;
  logic [CW-1:0]            cnt, cnt_nx;
  logic [UNROLL:0][63:0]    lane;

  // Round chain: lane j consumes rk[rk_addr-j], so keys descend within a cycle
  assign lane[0] = sreg;
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    boron_dec_round u_rnd (
      .x (lane[j]),
      .k (rk_data[64*j +: 64]),
      .y (lane[j+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= IDLE;
      sreg <= '0;
      cnt  <= '0;
    end else begin
      st   <= st_nx;
      sreg <= sreg_nx;
      cnt  <= cnt_nx;
    end
  end

  always_comb begin
    st_nx     = st;
    sreg_nx   = sreg;
    cnt_nx    = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_addr   = '0;
    dout      = '0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sreg_nx = din;
          cnt_nx  = '0;
          st_nx   = RUN;
        end
      end
      RUN: begin
        rk_addr = AW'(ROUNDS - int'(cnt) * UNROLL);
        sreg_nx = lane[UNROLL];
        cnt_nx  = cnt + CW'(1);
        if (cnt == CW'(N-1)) st_nx = FINAL;
      end
      FINAL: begin
        sreg_nx = sreg ^ rk_data[63:0];
        st_nx   = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        dout      = sreg;
        // Release only; a new block waits for the next IDLE cycle
        if (out_ready) st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end
endmodule
